// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: N-channel, WIDTH-bit registered multiplexer with valid/ready on every port,
// fixed-select (mode=0) or round-robin (mode=1) grant. Define MUX_COUNT_EN to add out_count.
module mux_nx1_reg #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               mode,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_ch
`ifdef MUX_COUNT_EN
   ,
   output logic [15:0]        out_count
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] out_data_reg;
   logic [SELW-1:0]  out_ch_reg;
   logic [SELW-1:0]  ptr_reg;
   logic [WIDTH-1:0] ch_word [N];
   logic             can_load;
   logic             grant;
   logic             load;
   logic [SELW-1:0]  g;
   logic [WIDTH-1:0] g_word;
   int               best_dist;
   int               cand_dist;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ch
         assign ch_word[gi]  = in_data[gi*WIDTH +: WIDTH];
         assign in_ready[gi] = ~rst & load & (g == SELW'(gi));
      end
   endgenerate

   assign can_load = (state_reg == EMPTY) | (out_ready & (state_reg == FULL));
   assign load     = grant & can_load;

   // Round-robin picks the valid channel with the smallest distance past ptr_reg.
   always_comb begin
      grant     = 1'b0;
      g         = '0;
      best_dist = N;
      cand_dist = 0;
      for (int k = 0; k < N; k++) begin
         if (mode == 1'b0) begin
            if (in_valid[k] && (sel == SELW'(k))) begin
               grant = 1'b1;
               g     = SELW'(k);
            end
         end else if (in_valid[k]) begin
            cand_dist = (k + N - 1 - int'(ptr_reg)) % N;
            if (cand_dist < best_dist) begin
               best_dist = cand_dist;
               grant     = 1'b1;
               g         = SELW'(k);
            end
         end
      end
   end

   always_comb begin
      g_word = '0;
      for (int k = 0; k < N; k++) begin
         if (g == SELW'(k)) begin
            g_word = ch_word[k];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (load) begin
         state_next = FULL;
      end else if ((state_reg == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= EMPTY;
         out_data_reg <= '0;
         out_ch_reg   <= '0;
         ptr_reg      <= SELW'(N - 1);
      end else begin
         state_reg <= state_next;
         if (load) begin
            out_data_reg <= g_word;
            out_ch_reg   <= g;
            if (mode) begin
               ptr_reg <= g;
            end
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign out_valid = (state_reg == FULL);

`ifdef MUX_COUNT_EN
   logic [15:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if ((state_reg == FULL) && out_ready) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign out_count = count_reg;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// tb_mux_nx1_reg: directed stimulus with a scoreboard queue; a negedge monitor pops and
// compares every output handshake. Exercises the counter when MUX_COUNT_EN is defined.
module tb_mux_nx1_reg;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic        mode;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;
`ifdef MUX_COUNT_EN
   logic [15:0] out_count;
   logic [15:0] out_count3;
`endif

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic        mode3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_ch3;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   quiet    = 1'b0;
   exp_t sb_q[$];
   logic [7:0] words [4] = '{8'hC1, 8'h3C, 8'hA5, 8'h5A};

   always #5 clk = ~clk;

   mux_nx1_reg #(.WIDTH(8), .N(4), .SELW(2)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch)
`ifdef MUX_COUNT_EN
      , .out_count(out_count)
`endif
   );

   mux_nx1_reg #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .sel(sel3), .mode(mode3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_ch(out_ch3)
`ifdef MUX_COUNT_EN
      , .out_count(out_count3)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch);
      exp_t e;
      e.ch   = 2'(ch);
      e.data = words[ch];
      sb_q.push_back(e);
   endtask

   // Monitor: every output handshake must match the oldest expected word.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got ch %0d data %0h expected no word", out_ch, out_data);
         end else begin
            e = sb_q.pop_front();
            if (!quiet) begin
               $display("out word: ch %0d data %0h (expected ch %0d data %0h)", out_ch, out_data, e.ch, e.data);
            end
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_ch", 32'(out_ch), 32'(e.ch));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      in_data    = {words[3], words[2], words[1], words[0]};
      in_valid   = 4'b1111;
      sel        = 2'd0;
      mode       = 1'b0;
      out_ready  = 1'b1;
      in_data3   = {8'h33, 8'h22, 8'h11};
      in_valid3  = 3'b000;
      sel3       = 2'd0;
      mode3      = 1'b0;
      out_ready3 = 1'b1;

      // Reset state.
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ch", 32'(out_ch), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;

      // Fixed select on channel 2.
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
      @(negedge clk);
      check("fix_in_ready", 32'(in_ready), 32'b0100);
      push(2);
      tick();
      in_valid = 4'b0000;
      @(negedge clk);
      check("fix_out_valid", 32'(out_valid), 32'd1);
      tick();

      // Round-robin: all valid, pointer still at 3 so channel 0 first.
      mode = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
         if (i > 0) check("rr_out_valid", 32'(out_valid), 32'd1);
         push(i % 4);
         tick();
      end
      in_valid = 4'b0000;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("rr_drained", 32'(out_valid), 32'd0);
      tick();

      // Backpressure: hold 3C for 5 cycles, then reload on the draining edge.
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_load", 32'(in_ready), 32'b0010);
      push(1);
      tick();
      out_ready = 1'b0; sel = 2'd3; in_valid = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_data", 32'(out_data), 32'h3C);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'b1000);
      push(3);
      tick();
      in_valid = 4'b0000;
      @(negedge clk);
      check("bp_reload_valid", 32'(out_valid), 32'd1);
      tick();

      // Reset mid-transfer: move the pointer to 1, hold a word, then reset.
      mode = 1'b1; out_ready = 1'b0; in_valid = 4'b0010;
      @(negedge clk);
      check("mid_in_ready", 32'(in_ready), 32'b0010);
      tick();
      in_valid = 4'b1111;
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_out_ch", 32'(out_ch), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_first_grant", 32'(in_ready), 32'b0001);
      push(0);
      tick();
      in_valid = 4'b0000;
      @(negedge clk);
      tick();

      // Invalid select on the 3-channel instance.
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("n3_bad_sel_in_ready", 32'(in_ready3), 32'd0);
         check("n3_bad_sel_out_valid", 32'(out_valid3), 32'd0);
         tick();
      end
      sel3 = 2'd2;
      @(negedge clk);
      check("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
      tick();
      in_valid3 = 3'b000;
      @(negedge clk);
      check("n3_sel2_out_data", 32'(out_data3), 32'h33);
      check("n3_sel2_out_ch", 32'(out_ch3), 32'd2);
      check("n3_sel2_out_valid", 32'(out_valid3), 32'd1);
      tick();

`ifdef MUX_COUNT_EN
      // Counter: 65537 handshakes wrap to 1; no increments while stalled.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("cnt_reset", 32'(out_count), 32'd0);
      tick();
      quiet = 1'b1;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         push(i % 4);
         tick();
      end
      in_valid = 4'b0000;
      @(negedge clk);
      tick();
      quiet = 1'b0;
      @(negedge clk);
      check("cnt_wrap", 32'(out_count), 32'd1);
      in_valid = 4'b0001; out_ready = 1'b0;
      push(0);
      tick();
      in_valid = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("cnt_stall", 32'(out_count), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      check("cnt_after_drain", 32'(out_count), 32'd2);
`endif

      tick();
      tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised N-input, WIDTH-bit channel multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Next generation of the 2:1 single-bit select mux built from AND/OR/NOT gates.
- Adds multi-bit data, arbitrary channel count, and a fixed-select or round-robin mode.
- Sits between multiple producer streams and one consumer; one word per cycle maximum throughput.

Parameters:
WIDTH, 8, data bits per channel
N, 4, number of input channels (2..16)
SELW, 2, select/channel-id width; must satisfy 2**SELW >= N

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept; combinational from state, mode, sel, in_valid
sel  input  SELW  channel select, used when mode=0
mode  input  1  0 = fixed select, 1 = round-robin
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accept
out_ch  output  SELW  channel id the current out_data came from

Behaviour:
- Reset (async, rst=1): out_data=0, out_valid=0, out_ch=0, rr pointer=N-1 (so channel 0 has first priority), state=EMPTY. in_ready=0 while rst is high.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: can_load = (state==EMPTY) | (out_ready & out_valid). This allows a new word to load in the same cycle the held word drains, giving full throughput.
- Grant, mode=0:
  - g = sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - sel >= N: never grants; all in_ready=0.
- Grant, mode=1:
  - Search channels ptr+1, ptr+2, ... modulo N.
  - Grant the first one with in_valid=1; no grant if none is valid.
- in_ready[k] = can_load & (k==g) & grant. At most one in_ready is high per cycle.
- Transfer when grant & can_load. On the next edge:
  - out_data = in_data[g]; out_ch = g; state=FULL.
  - In mode=1 only: ptr=g. The pointer is untouched in mode=0.
- Drain with no new grant (FULL, out_ready=1, no grant): next state=EMPTY, out_valid=0. out_data and out_ch hold their old values.
- FULL with out_ready=0: out_data, out_ch and out_valid held stable; in_ready all 0.
- Latency: 1 cycle from an input handshake to out_valid.
- mode or sel changes take effect on the next grant evaluation. A word already held in the output register is unaffected.
- Pointer wrap: with ptr=N-1 the search starts at channel 0.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately (async), and the pointer returns to N-1.
- No combinational path from out_ready to out_data.

Optional Feature:
MUX_COUNT_EN:
- Defined:
  - Adds output port out_count, 16 bits.
  - Increments by 1 on every output handshake (out_valid & out_ready).
  - Wraps from 16'hFFFF to 0.
  - Reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; after release with mode=1 and all in_valid=1, the first grant is channel 0.
- Fixed select: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 on consecutive cycles, one word per cycle.
- Backpressure: out_valid=1 with word 8'h3C, out_ready=0 for 5 cycles -> out_data stays 8'h3C, in_ready=0; out_ready=1 -> the next word loads on the same edge as the drain.
- Invalid select: N=3 build, mode=0, sel=3, all in_valid=1 -> in_ready=0, out_valid remains 0.
- Counter (MUX_COUNT_EN): preload via 65537 handshakes -> out_count=1 after wrap; with out_ready=0 there are no increments.
